// File: rtl/boot_mem_pkg.sv
// Shared types for the boot memory: boot sequencing state
// and the bus drive selector.
`include "top_macro.vh"

package boot_mem_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } boot_state_t;

    typedef enum logic [1:0] {
        BUS_HIZ  = 2'd0,
        BUS_READ = 2'd1,
        BUS_LOAD = 2'd2
    } bus_mode_t;

    // Selects who owns the shared data bus this cycle.
    function automatic bus_mode_t bus_mode_of(
        input logic wr,
        input logic active
    );
        bus_mode_t m;
        m = BUS_HIZ;
        if (!wr) begin
            m = BUS_READ;
        end else if (active) begin
            m = BUS_LOAD;
        end
        return m;
    endfunction

endpackage

// File: rtl/boot_fifo.sv
// Staging FIFO between the host image stream and the boot writer.
// Pointers carry one extra wrap bit to tell full from empty.
module boot_fifo
    import boot_mem_pkg::*;
#(
    parameter int WORD_W     = `WORD_SIZE,
    parameter int FIFO_DEPTH = `BOOT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WORD_W-1:0] store [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head = store[rd_ptr[PTR_W-1:0]];

    // Entry storage; contents need no reset, occupancy is tracked by pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/top_macro.vh
// Shared bus geometry and boot loader defaults.
// Used by boot_mem and by cpu_test for the end-of-sweep address.
`ifndef TOP_MACRO_VH
`define TOP_MACRO_VH

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

// Byte address of the last word written by the boot sweep.
`ifndef BOOT_LAST_ADDR
`define BOOT_LAST_ADDR ((1 << `ADDR_SIZE) - 2)
`endif

`ifndef BOOT_FIFO_DEPTH
`define BOOT_FIFO_DEPTH 4
`endif

`endif

// File: rtl/boot_mem.sv
// Unified program/data memory with an in-line boot image loader.
// Optional BOOT_CHECKSUM_EN adds a running sum of boot-written words.
`include "top_macro.vh"

module boot_mem
    import boot_mem_pkg::*;
#(
    parameter int WORD_W     = `WORD_SIZE,
    parameter int ADDR_W     = `ADDR_SIZE,
    parameter int FIFO_DEPTH = `BOOT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_bus,
    inout  wire  [WORD_W-1:0] data_bus,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              boot_active,
`ifdef BOOT_CHECKSUM_EN
    output logic [WORD_W-1:0] boot_sum,
`endif
    output logic              boot_underrun
);

    localparam int WORDS = 2 ** (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W - 1){1'b1}}, 1'b0};

    boot_state_t       state;
    boot_state_t       state_nxt;
    bus_mode_t         bus_mode;

    logic [WORD_W-1:0] mem [WORDS];
    logic [ADDR_W-2:0] idx;
    logic              wr;
    logic              boot_wr;
    logic              last_hit;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] load_word;
    logic [WORD_W-1:0] wdata;

    // An undriven or unknown strobe must fall back to a read cycle.
    assign wr       = (wr_en === 1'b1);
    assign idx      = addr_bus[ADDR_W-1:1];
    assign boot_wr  = boot_active && wr;
    assign last_hit = (addr_bus == LAST_ADDR);

    assign ld_ready  = !fifo_full && boot_active;
    assign fifo_push = ld_valid && ld_ready;
    assign fifo_pop  = boot_wr && !fifo_empty;

    // An empty FIFO during a boot write loads zero.
    assign load_word = fifo_empty ? '0 : fifo_head;

    // The loader value is used directly in boot; after boot the CPU owns the bus.
    assign wdata = boot_active ? load_word : data_bus;

    boot_fifo #(
        .WORD_W    (WORD_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (ld_data),
        .head (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Boot sequencing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave boot once the last word of the sweep is written.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_BOOT: begin
                if (wr && last_hit) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // Decode state into status and bus ownership.
    always_comb begin
        boot_active = (state == ST_BOOT);
        bus_mode    = bus_mode_of(wr, boot_active);
    end

    assign data_bus = (bus_mode == BUS_READ) ? mem[idx] :
                      (bus_mode == BUS_LOAD) ? load_word :
                      {WORD_W{1'bz}};

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[idx] <= wdata;
        end
    end

    // Sticky flag for a boot write that found no staged word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_underrun <= 1'b0;
        end else if (boot_wr && fifo_empty) begin
            boot_underrun <= 1'b1;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Accumulate every boot-written word; frozen after boot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_sum <= '0;
        end else if (boot_wr) begin
            boot_sum <= boot_sum + load_word;
        end
    end
`endif

endmodule

// File: tb/tb_boot_mem.sv
// Directed bench for boot_mem: boot fill, backpressure, underrun,
// post-boot CPU traffic, mid-boot reset and optional checksum.
module tb_boot_mem;

    logic        clk;
    logic        rst;
    logic [7:0]  addr_bus;
    wire  [15:0] data_bus;
    logic        wr_en;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        boot_active;
    logic        boot_underrun;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] boot_sum;
`endif

    logic        cpu_oe;
    logic [15:0] cpu_drv;
    int          n_assert;
    int          n_fail;
    int          h;
    logic        acc;
    logic [15:0] zword;

    assign data_bus = cpu_oe ? cpu_drv : 16'hzzzz;

    boot_mem dut (
        .clk          (clk),
        .rst          (rst),
        .addr_bus     (addr_bus),
        .data_bus     (data_bus),
        .wr_en        (wr_en),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .boot_active  (boot_active),
`ifdef BOOT_CHECKSUM_EN
        .boot_sum     (boot_sum),
`endif
        .boot_underrun(boot_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU read of word i through the bus.
    task automatic rd(input int i, input logic [15:0] exp);
        wr_en    = 1'b0;
        addr_bus = 8'(2 * i);
        #1;
        chk("read", data_bus, exp);
        tick();
    endtask

    // Boot sweep over words lo..hi while the host streams base+h.
    task automatic sweep(input int lo, input int hi, input logic [15:0] base);
        for (int i = lo; i <= hi; i++) begin
            addr_bus = 8'(2 * i);
            wr_en    = 1'b1;
            ld_valid = (h < 128);
            ld_data  = base + 16'(h);
            #1;
            chk("sweep_data", data_bus, base + 16'(i));
            if (i == 127) chk("active_before_last", 16'(boot_active), 16'd1);
            acc = ld_ready && ld_valid;
            tick();
            if (acc) h++;
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        h        = 0;
        zword    = 16'hzzzz;
        cpu_oe   = 1'b0;
        cpu_drv  = 16'h0000;
        addr_bus = 8'd0;
        wr_en    = 1'b0;
        ld_data  = 16'h0000;
        ld_valid = 1'b0;
        rst      = 1'b1;
        #2;
        chk("rst_active", 16'(boot_active), 16'd1);
        chk("rst_underrun", 16'(boot_underrun), 16'd0);
        chk("rst_ready", 16'(ld_ready), 16'd1);
`ifdef BOOT_CHECKSUM_EN
        chk("rst_sum", boot_sum, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Backpressure: four pushes fill the FIFO.
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_data  = 16'h1000 + 16'(k);
            #1;
            chk("ready_fill", 16'(ld_ready), 16'd1);
            tick();
        end
        ld_data = 16'h1004;
        #1;
        chk("ready_full", 16'(ld_ready), 16'd0);
        tick();
        wr_en    = 1'b1;
        addr_bus = 8'd0;
        #1;
        chk("ready_held", 16'(ld_ready), 16'd0);
        chk("first_head", data_bus, 16'h1000);
        tick();
        chk("ready_after_pop", 16'(ld_ready), 16'd1);
        h = 4;

        // Boot fill of the remaining words.
        sweep(1, 127, 16'h1000);
        chk("boot_done", 16'(boot_active), 16'd0);
        chk("fill_underrun", 16'(boot_underrun), 16'd0);
        chk("ready_post_boot", 16'(ld_ready), 16'd0);
        rd(0, 16'h1000);
        rd(64, 16'h1040);
        rd(127, 16'h107f);

        // Post-boot CPU traffic.
        rd(2, 16'h1002);
        wr_en    = 1'b1;
        addr_bus = 8'd8;
        cpu_oe   = 1'b1;
        cpu_drv  = 16'hbeef;
        #1;
        chk("cpu_drive", data_bus, 16'hbeef);
        cpu_oe = 1'b0;
        #1;
        chk("mem_hiz", data_bus, zword);
        cpu_oe = 1'b1;
        tick();
        cpu_oe = 1'b0;
        rd(4, 16'hbeef);
        rd(5, 16'h1005);

        // Underrun on a fresh boot with the host idle.
        rst = 1'b1;
        #1;
        chk("rst2_active", 16'(boot_active), 16'd1);
        chk("rst2_ready", 16'(ld_ready), 16'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        wr_en    = 1'b1;
        addr_bus = 8'd0;
        #1;
        chk("underrun_drive", data_bus, 16'h0000);
        chk("underrun_pre", 16'(boot_underrun), 16'd0);
        tick();
        chk("underrun_set", 16'(boot_underrun), 16'd1);
        addr_bus = 8'd2;
        tick();
        chk("underrun_sticky", 16'(boot_underrun), 16'd1);
        rd(0, 16'h0000);
        rd(1, 16'h0000);

        // Reset mid-boot with two words queued at addr 100.
        for (h = 2; h < 4; h++) begin
            ld_valid = 1'b1;
            ld_data  = 16'h2000 + 16'(h);
            tick();
        end
        sweep(2, 49, 16'h2000);
        addr_bus = 8'd100;
        wr_en    = 1'b1;
        rst      = 1'b1;
        #1;
        chk("mid_active", 16'(boot_active), 16'd1);
        chk("mid_underrun", 16'(boot_underrun), 16'd0);
        chk("mid_ready", 16'(ld_ready), 16'd1);
        chk("mid_empty", data_bus, 16'h0000);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        rd(0, 16'h0000);
        rd(2, 16'h2002);
        rd(49, 16'h2031);
        rd(50, 16'h1032);

        // Full boot with words 1..128.
        h        = 0;
        ld_valid = 1'b1;
        ld_data  = 16'd1;
        tick();
        h = 1;
        sweep(0, 127, 16'd1);
        chk("boot2_done", 16'(boot_active), 16'd0);
`ifdef BOOT_CHECKSUM_EN
        chk("sum", boot_sum, 16'd8256);
`endif
        wr_en    = 1'b1;
        addr_bus = 8'd0;
        cpu_oe   = 1'b1;
        cpu_drv  = 16'h1234;
        tick();
        cpu_oe = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        chk("sum_frozen", boot_sum, 16'd8256);
`endif
        rd(0, 16'h1234);
        rd(127, 16'd128);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
